segment_id_ex_hs: RTL and testbench

Parametrised successor to the ID/EX pipeline segment register. It carries the decode-stage control and data bundle into execute using a valid/ready handshake, a 2-entry skid buffer, and a synchronous flush. The block sits between decode and execute in RSA_PIPELINE_CPU. The hazard unit uses it to stall execute (out_ready=0) without a combinational ready path back into decode, and to squash wrong-path instructions after a taken branch.

---
 rtl/segment_id_ex_hs.sv | 132 +++++++++++++
 tb/tb_segment_id_ex_hs.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/segment_id_ex_hs.sv
// ID/EX segment register with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
// State updates on the falling clock edge, the same edge as the other pipeline segment registers.
module segment_id_ex_hs #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 4,
  parameter int ALUCTL_W = 3,
  parameter int FLAG_W   = 2,
  parameter int COND_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                PCSrcD,
  input  logic                RegWriteD,
  input  logic                MemtoRegD,
  input  logic                MemWriteD,
  input  logic                BranchD,
  input  logic                ALUSrcD,
  input  logic [ALUCTL_W-1:0] ALUControlD,
  input  logic [FLAG_W-1:0]   FlagWriteD,
  input  logic [COND_W-1:0]   condD,
  input  logic [REG_AW-1:0]   WA3D,
  input  logic [DATA_W-1:0]   rd1D,
  input  logic [DATA_W-1:0]   rd2D,
  input  logic [DATA_W-1:0]   ExtImmD,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                PCSrcE,
  output logic                RegWriteE,
  output logic                MemtoRegE,
  output logic                MemWriteE,
  output logic                BranchE,
  output logic                ALUSrcE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic [FLAG_W-1:0]   FlagWriteE,
  output logic [COND_W-1:0]   condE,
  output logic [REG_AW-1:0]   WA3E,
  output logic [DATA_W-1:0]   rd1E,
  output logic [DATA_W-1:0]   rd2E,
  output logic [DATA_W-1:0]   ExtImmE,
  output logic [1:0]          occupancy
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic                pcsrc;
    logic                regwrite;
    logic                memtoreg;
    logic                memwrite;
    logic [ALUCTL_W-1:0] aluctl;
    logic                branch;
    logic                alusrc;
    logic [FLAG_W-1:0]   flagwrite;
    logic [COND_W-1:0]   cond;
    logic [REG_AW-1:0]   wa3;
    logic [DATA_W-1:0]   rd1;
    logic [DATA_W-1:0]   rd2;
    logic [DATA_W-1:0]   extimm;
  } bundle_t;

  state_t  state;
  bundle_t p, m, s;
  logic    acc_in, acc_out;

  assign p = '{pcsrc: PCSrcD, regwrite: RegWriteD, memtoreg: MemtoRegD, memwrite: MemWriteD,
               aluctl: ALUControlD, branch: BranchD, alusrc: ALUSrcD, flagwrite: FlagWriteD,
               cond: condD, wa3: WA3D, rd1: rd1D, rd2: rd2D, extimm: ExtImmD};

  // Handshake flags decode only registered state, so in_ready never depends on out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign acc_in    = in_valid & in_ready;
  assign acc_out   = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge clk) begin
    if (rst) begin
      state <= EMPTY;
      m     <= '0;
      s     <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc_in) begin
          m     <= p;
          state <= ONE;
        end
        ONE: begin
          if (acc_in && acc_out) begin
            m <= p;
          end else if (acc_in) begin
            s     <= p;
            state <= TWO;
          end else if (acc_out) begin
            state <= EMPTY;
          end
        end
        TWO: if (acc_out) begin
          m     <= s;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Side-effecting controls are gated so an empty segment always presents a bubble.
  assign PCSrcE      = m.pcsrc    & out_valid;
  assign RegWriteE   = m.regwrite & out_valid;
  assign MemWriteE   = m.memwrite & out_valid;
  assign BranchE     = m.branch   & out_valid;
  assign FlagWriteE  = m.flagwrite & {FLAG_W{out_valid}};
  assign MemtoRegE   = m.memtoreg;
  assign ALUSrcE     = m.alusrc;
  assign ALUControlE = m.aluctl;
  assign condE       = m.cond;
  assign WA3E        = m.wa3;
  assign rd1E        = m.rd1;
  assign rd2E        = m.rd2;
  assign ExtImmE     = m.extimm;

endmodule

// File: tb/tb_segment_id_ex_hs.sv
// Bench for segment_id_ex_hs: directed scenarios then random traffic, checked against a queue model.
module tb_segment_id_ex_hs;

  typedef struct packed {
    logic        pcsrc;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic [2:0]  aluctl;
    logic        branch;
    logic        alusrc;
    logic [1:0]  flagwrite;
    logic [3:0]  cond;
    logic [3:0]  wa3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] extimm;
  } bun_t;

  logic        clk = 1'b1;
  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [1:0]  occupancy;
  bun_t        in_b = '0;
  bun_t        out_b;
  logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [1:0]  FlagWriteE;
  logic [3:0]  condE, WA3E;
  logic [31:0] rd1E, rd2E, ExtImmE;

  int   n_checks = 0;
  int   n_fail   = 0;
  bun_t q[$];
  bun_t m_model = '0;

  always #5 clk = ~clk;

  segment_id_ex_hs dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .PCSrcD(in_b.pcsrc), .RegWriteD(in_b.regwrite), .MemtoRegD(in_b.memtoreg),
    .MemWriteD(in_b.memwrite), .BranchD(in_b.branch), .ALUSrcD(in_b.alusrc),
    .ALUControlD(in_b.aluctl), .FlagWriteD(in_b.flagwrite), .condD(in_b.cond),
    .WA3D(in_b.wa3), .rd1D(in_b.rd1), .rd2D(in_b.rd2), .ExtImmD(in_b.extimm),
    .out_valid(out_valid), .out_ready(out_ready),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE),
    .condE(condE), .WA3E(WA3E), .rd1E(rd1E), .rd2E(rd2E), .ExtImmE(ExtImmE),
    .occupancy(occupancy)
  );

  assign out_b = {PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ALUControlE, BranchE, ALUSrcE,
                  FlagWriteE, condE, WA3E, rd1E, rd2E, ExtImmE};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bun_t exp;
    exp = m_model;
    if (q.size() == 0) begin
      exp.pcsrc = 1'b0; exp.regwrite = 1'b0; exp.memwrite = 1'b0;
      exp.branch = 1'b0; exp.flagwrite = '0;
    end
    check({tag, ".out_valid"}, 128'(out_valid), 128'(q.size() > 0));
    check({tag, ".in_ready"},  128'(in_ready),  128'(q.size() < 2));
    check({tag, ".occupancy"}, 128'(occupancy), 128'(q.size()));
    check({tag, ".bundle"},    128'(out_b),     128'(exp));
  endtask

  // Model: a FIFO of at most two bundles; the E outputs show the head, or the last head once drained.
  task automatic cycle(input string tag);
    bit ao, ai;
    ao = (q.size() > 0) && out_ready;
    ai = in_valid && (q.size() < 2);
    if (rst) begin
      q.delete();
      m_model = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (ao) void'(q.pop_front());
      if (ai) q.push_back(in_b);
      if (q.size() > 0) m_model = q[0];
    end
    @(negedge clk);
    #1;
    check_all(tag);
  endtask

  function automatic bun_t rand_b();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return bun_t'(r[$bits(bun_t)-1:0]);
  endfunction

  initial begin
    // Reset with a live input bundle that must not leak through.
    in_b = rand_b(); in_b.regwrite = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle("reset0");
    cycle("reset1");
    check("reset.rd1E", 128'(rd1E), 128'(0));
    rst = 1'b0;

    // Streaming at full throughput.
    for (int i = 1; i <= 4; i++) begin
      in_b = rand_b(); in_b.rd1 = i;
      cycle("stream");
      check("stream.rd1E", 128'(rd1E), 128'(i));
    end
    in_valid = 1'b0;
    cycle("stream_drain");

    // Back-pressure fills the skid entry, then drains in order.
    out_ready = 1'b0; in_valid = 1'b1;
    in_b = rand_b(); in_b.rd1 = 32'hA; cycle("bp_a");
    in_b = rand_b(); in_b.rd1 = 32'hB; cycle("bp_b");
    check("bp.rd1E_held", 128'(rd1E), 128'(32'hA));
    in_valid = 1'b0; out_ready = 1'b1;
    cycle("bp_pop_a");
    check("bp.rd1E_next", 128'(rd1E), 128'(32'hB));
    cycle("bp_pop_b");

    // Flush while full, with a new bundle presented in the same cycle.
    out_ready = 1'b0; in_valid = 1'b1;
    in_b = rand_b(); in_b.memwrite = 1'b1; in_b.regwrite = 1'b1; cycle("fl_fill0");
    in_b = rand_b(); in_b.memwrite = 1'b1; cycle("fl_fill1");
    flush = 1'b1; in_b = rand_b(); in_b.memwrite = 1'b1;
    cycle("flush");
    check("flush.MemWriteE", 128'(MemWriteE), 128'(0));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle("flush_idle");

    // Simultaneous accept and consume holds occupancy at one.
    in_valid = 1'b1; in_b = rand_b(); cycle("sim_prime");
    for (int i = 0; i < 10; i++) begin
      in_b = rand_b();
      cycle("sim");
    end
    in_valid = 1'b0; cycle("sim_drain");

    // Reset and flush together while full: reset wins and clears data.
    out_ready = 1'b0; in_valid = 1'b1;
    in_b = rand_b(); in_b.rd1 = 32'h1234_5678; cycle("rf_fill0");
    in_b = rand_b(); cycle("rf_fill1");
    rst = 1'b1; flush = 1'b1; cycle("rst_flush");
    check("rst_flush.rd1E", 128'(rd1E), 128'(0));
    rst = 1'b0; flush = 1'b0;

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      in_b      = rand_b();
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 15) == 0;
      rst       = $urandom_range(0, 63) == 0;
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
